// File: rtl/mem_arbiter_pkg.sv
// Shared types for mem_arbiter: FSM state and access-owner encodings.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;

    typedef enum logic {ARB_OWNER_I, ARB_OWNER_D} arb_owner_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational winner select between fetch (I) and data (D) requesters.
// MEM_ARBITER_RR_EN selects round-robin on last_winner; otherwise D-priority with a starvation override.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       i_elig,
    input  logic       d_elig,
`ifdef MEM_ARBITER_RR_EN
    input  arb_owner_t last_winner,
`else
    input  logic       starve_hit,
`endif
    output logic       grant_valid,
    output arb_owner_t grant_owner
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant_valid = i_elig | d_elig;
        grant_owner = ARB_OWNER_D;
        if (i_elig && d_elig) begin
`ifdef MEM_ARBITER_RR_EN
            grant_owner = (last_winner == ARB_OWNER_D) ? ARB_OWNER_I : ARB_OWNER_D;
`else
            grant_owner = starve_hit ? ARB_OWNER_I : ARB_OWNER_D;
`endif
        end else if (i_elig) begin
            grant_owner = ARB_OWNER_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a fetch (I) and a data (D) requester.
// Build option MEM_ARBITER_RR_EN swaps D-priority + starvation guard for round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_write_enable,
    input  logic [DATA_W-1:0] d_write_data,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic       i_elig, d_elig, arb_en, grant_valid;
    arb_owner_t grant_owner;

    // The owner in RESP still holds req high; it must not win its own re-arbitration.
    assign i_elig = i_req && !(state_q == ARB_RESP && owner_q == ARB_OWNER_I);
    assign d_elig = d_req && !(state_q == ARB_RESP && owner_q == ARB_OWNER_D);
    assign arb_en = (state_q == ARB_IDLE) || (state_q == ARB_RESP);

`ifdef MEM_ARBITER_RR_EN
    arb_owner_t last_winner_q, last_winner_d;

    arb_pick u_pick (
        .i_elig      (i_elig),
        .d_elig      (d_elig),
        .last_winner (last_winner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             starve_hit;

    assign starve_hit = (starve_q == CNT_W'(STARVE_LIMIT));

    arb_pick u_pick (
        .i_elig      (i_elig),
        .d_elig      (d_elig),
        .starve_hit  (starve_hit),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef MEM_ARBITER_RR_EN
        last_winner_d = last_winner_q;
`else
        starve_d = starve_q;
`endif

        unique case (state_q)
            ARB_IDLE:   if (grant_valid) state_d = ARB_ACCESS;
            ARB_ACCESS: begin
                if (owner_q == ARB_OWNER_I) i_rdata_d = mem_data;
                else                        d_rdata_d = mem_data;
                state_d = ARB_RESP;
            end
            ARB_RESP:   state_d = grant_valid ? ARB_ACCESS : ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase

        if (arb_en && grant_valid) begin
            owner_d = grant_owner;
            if (grant_owner == ARB_OWNER_I) begin
                addr_d  = i_address;
                wdata_d = '0;
                we_d    = 1'b0;
            end else begin
                addr_d  = d_address;
                wdata_d = d_write_data;
                we_d    = d_write_enable;
            end
`ifdef MEM_ARBITER_RR_EN
            last_winner_d = grant_owner;
`else
            // Count only real losses: I was eligible and D took the grant.
            if (grant_owner == ARB_OWNER_I)        starve_d = '0;
            else if (i_elig && !starve_hit)        starve_d = starve_q + CNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB_IDLE;
            owner_q   <= ARB_OWNER_I;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_winner_q <= ARB_OWNER_D;
`else
            starve_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARBITER_RR_EN
            last_winner_q <= last_winner_d;
`else
            starve_q <= starve_d;
`endif
        end
    end

    // Write strobe decoded from state so an async reset in ACCESS kills it at once.
    assign mem_write_enable = (state_q == ARB_ACCESS) && we_q;
    assign mem_address      = addr_q;
    assign mem_write_data   = wdata_q;
    assign busy             = (state_q != ARB_IDLE);
    assign i_ack            = (state_q == ARB_RESP) && (owner_q == ARB_OWNER_I);
    assign d_ack            = (state_q == ARB_RESP) && (owner_q == ARB_OWNER_D);
    assign i_rdata          = i_rdata_q;
    assign d_rdata          = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected acks, a negedge monitor pops them.
// Builds with or without MEM_ARBITER_RR_EN; the arbitration-policy test follows the build.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, d_req, d_write_enable;
    logic [31:0] i_address, d_address, d_write_data;
    logic        i_ack, d_ack, mem_write_enable, busy;
    logic [31:0] i_rdata, d_rdata, mem_address, mem_write_data, mem_data;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_req            (i_req),
        .i_address        (i_address),
        .i_ack            (i_ack),
        .i_rdata          (i_rdata),
        .d_req            (d_req),
        .d_address        (d_address),
        .d_write_enable   (d_write_enable),
        .d_write_data     (d_write_data),
        .d_ack            (d_ack),
        .d_rdata          (d_rdata),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_data         (mem_data),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Small word memory with combinational read; out-of-range addresses read 0.
    logic [31:0] mem [0:255];
    logic        mem_oob;
    int          writes = 0;
    assign mem_oob  = |{mem_address[31:10], mem_address[1:0]};
    assign mem_data = mem_oob ? 32'h0 : mem[mem_address[9:2]];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            writes++;
            if (!mem_oob) mem[mem_address[9:2]] = mem_write_data;
        end
    end

    typedef struct {
        bit          is_d;
        bit          chk;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input bit is_d, input bit chk, input logic [31:0] data, input string name);
        exp_t e;
        e.is_d = is_d;
        e.chk  = chk;
        e.data = data;
        e.name = name;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_n && (i_ack || d_ack)) begin
            if (i_ack && d_ack) begin
                check("both_acks", 32'd1, 32'd0);
            end else if (sb_q.size() == 0) begin
                check("unexpected_ack", {30'd0, d_ack, i_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_owner"}, {31'd0, d_ack}, {31'd0, e.is_d});
                if (e.chk) check({e.name, "_data"}, d_ack ? d_rdata : i_rdata, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ack(input bit is_d, output int edges);
        edges = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            edges++;
            if (is_d ? d_ack : i_ack) return;
        end
        check(is_d ? "d_ack_timeout" : "i_ack_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n, w0, it, dt, in_n, dn_n;
        bit done;

        reset_n = 1'b0;
        {i_req, d_req, d_write_enable} = '0;
        {i_address, d_address, d_write_data} = '0;
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        mem[2] = 32'h0050_0093;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_i_ack", {31'd0, i_ack}, 32'd0);
        check("rst_d_ack", {31'd0, d_ack}, 32'd0);
        check("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1. Fetch only: ack on the second edge after req
        w0 = writes;
        i_address = 32'h8;
        i_req = 1'b1;
        push(0, 1, 32'h0050_0093, "fetch");
        wait_ack(0, n);
        i_req = 1'b0;
        check("fetch_latency", n, 32'd2);
        @(negedge clk);
        check("fetch_no_write", writes - w0, 32'd0);

        // 2. Store then load of 0x40
        w0 = writes;
        d_address = 32'h40;
        d_write_enable = 1'b1;
        d_write_data = 32'hDEAD_BEEF;
        d_req = 1'b1;
        push(1, 0, 32'h0, "store");
        wait_ack(1, n);
        d_req = 1'b0;
        d_write_enable = 1'b0;
        @(negedge clk);
        check("store_one_write", writes - w0, 32'd1);
        d_req = 1'b1;
        push(1, 1, 32'hDEAD_BEEF, "load");
        wait_ack(1, n);
        d_req = 1'b0;
        @(negedge clk);
        check("load_no_write", writes - w0, 32'd1);

        // 3. Contention: both rise together, second ack two cycles after the first
`ifdef MEM_ARBITER_RR_EN
        push(0, 1, 32'h0050_0093, "cont_fetch");
        push(1, 1, 32'hDEAD_BEEF, "cont_load");
`else
        push(1, 1, 32'hDEAD_BEEF, "cont_load");
        push(0, 1, 32'h0050_0093, "cont_fetch");
`endif
        i_req = 1'b1;
        d_req = 1'b1;
        it = -1;
        dt = -1;
        for (int c = 1; c <= 20 && (it < 0 || dt < 0); c++) begin
            @(negedge clk);
            if (d_ack) begin dt = c; d_req = 1'b0; end
            if (i_ack) begin it = c; i_req = 1'b0; end
        end
`ifdef MEM_ARBITER_RR_EN
        check("cont_gap", dt - it, 32'd2);
`else
        check("cont_gap", it - dt, 32'd2);
`endif
        repeat (2) @(negedge clk);

`ifndef MEM_ARBITER_RR_EN
        // 4. Starvation guard: I re-requests only while idle, so every contended arbitration
        // happens in IDLE; D wins four times, I wins the fifth, then the count restarts.
        for (int k = 0; k < 4; k++) push(1, 1, 32'hDEAD_BEEF, "starve_d");
        push(0, 1, 32'h0050_0093, "starve_i1");
        for (int k = 0; k < 5; k++) push(1, 1, 32'hDEAD_BEEF, "starve_d");
        push(0, 1, 32'h0050_0093, "starve_i2");
        push(1, 1, 32'hDEAD_BEEF, "starve_d_last");
        i_req = 1'b1;
        d_req = 1'b1;
        in_n = 0;
        dn_n = 0;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (i_ack) in_n++;
            if (d_ack) begin
                dn_n++;
                if (dn_n == 10) d_req = 1'b0;
            end
            i_req = (in_n < 2) && !busy;
            done = (in_n == 2) && (dn_n == 10);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check("starve_done", {31'd0, done}, 32'd1);
        repeat (2) @(negedge clk);
`endif

        // 6. Reset during ACCESS of a store: write must not land
        mem[16] = 32'h1;
        w0 = writes;
        d_address = 32'h40;
        d_write_enable = 1'b1;
        d_write_data = 32'hCAFE_F00D;
        d_req = 1'b1;
        @(negedge clk);
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        check("rst_pre_we", {31'd0, mem_write_enable}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_we", {31'd0, mem_write_enable}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_acks", {30'd0, d_ack, i_ack}, 32'd0);
        d_req = 1'b0;
        d_write_enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mem_kept", mem[16], 32'h1);
        check("rst_no_write", writes - w0, 32'd0);
        check("rst_idle", {31'd0, busy}, 32'd0);

`ifdef MEM_ARBITER_RR_EN
        // 5. Round-robin from reset: both held, grants alternate starting with I
        push(0, 1, 32'h0050_0093, "rr_i1");
        push(1, 1, 32'h1, "rr_d1");
        push(0, 1, 32'h0050_0093, "rr_i2");
        push(1, 1, 32'h1, "rr_d2");
        i_address = 32'h8;
        d_address = 32'h40;
        i_req = 1'b1;
        d_req = 1'b1;
        in_n = 0;
        dn_n = 0;
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (i_ack) begin in_n++; if (in_n == 2) i_req = 1'b0; end
            if (d_ack) begin dn_n++; if (dn_n == 2) d_req = 1'b0; end
            done = (in_n == 2) && (dn_n == 2);
        end
        check("rr_done", {31'd0, done}, 32'd1);
        repeat (2) @(negedge clk);
`endif

        check("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
